broken_array_multiplier8_xor_enc32: RTL and testbench



---
 rtl/bam_pkg.sv | 15 +
 rtl/bam_full_adder.sv | 11 +
 rtl/broken_array_multiplier8_xor_enc32.sv | 81 ++++++++
 tb/tb_broken_array_multiplier8_xor_enc32.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bam_pkg.sv
// Shared widths, break levels and unlocking key for the locked broken-array multiplier.
package bam_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int KEY_W = 32;

  localparam int HBL_DEF = 0;
  localparam int VBL_DEF = 4;
  localparam logic [KEY_W-1:0] KEY_CORRECT_DEF = 32'hB544B006;

  // A key bit of 1 selects an XNOR gate, 0 an XOR gate, so the correct key is transparent.
  function automatic logic key_gate(input logic i_net, input logic i_key, input logic i_kc);
    return i_kc ? ~(i_net ^ i_key) : (i_net ^ i_key);
  endfunction
endpackage

// File: rtl/bam_full_adder.sv
// One-bit full adder cell used throughout the carry-save array and final ripple row.
module bam_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_cry
);
  assign o_sum = i_a ^ i_b ^ i_c;
  assign o_cry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/broken_array_multiplier8_xor_enc32.sv
// Key-locked 8x8 broken-array approximate multiplier with a registered 16-bit result.
module broken_array_multiplier8_xor_enc32
  import bam_pkg::*;
#(
  parameter int HBL = HBL_DEF,
  parameter int VBL = VBL_DEF,
  parameter logic [KEY_W-1:0] KEY_CORRECT = KEY_CORRECT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [OP_W-1:0]   operand1_i,
  input  logic [OP_W-1:0]   operand2_i,
  input  logic [KEY_W-1:0]  keyinput,
  output logic [RES_W-1:0]  result_o
);
  logic [OP_W-1:0]        w_a_eff;
  logic [OP_W-1:0]        w_b_eff;
  logic [OP_W:0][RES_W-1:0] w_sum;
  logic [OP_W:0][RES_W-1:0] w_cry;
  logic [RES_W-1:0]       w_rc;
  logic [RES_W-1:0]       w_p;
  logic [RES_W-1:0]       w_p_locked;
  logic [RES_W-1:0]       r_result;

  for (genvar j = 0; j < OP_W; j++) begin : g_op_gate
    assign w_a_eff[j] = key_gate(operand1_i[j], keyinput[16+j], KEY_CORRECT[16+j]);
    assign w_b_eff[j] = key_gate(operand2_i[j], keyinput[24+j], KEY_CORRECT[24+j]);
  end

  assign w_sum[0] = '0;
  assign w_cry[0] = '0;

  // Each row compresses (sum, carry, partial-product row) 3:2; omitted cells are tied
  // to 0 so their adders collapse away in synthesis.
  for (genvar i = 0; i < OP_W; i++) begin : g_row
    assign w_cry[i+1][0] = 1'b0;
    for (genvar k = 0; k < RES_W; k++) begin : g_col
      logic w_pp;
      if (k >= i && (k - i) < OP_W && i >= HBL && k >= VBL) begin : g_cell
        assign w_pp = w_b_eff[i] & w_a_eff[k-i];
      end else begin : g_hole
        assign w_pp = 1'b0;
      end
      if (k < RES_W-1) begin : g_fa
        bam_full_adder u_fa (
          .i_a  (w_sum[i][k]),
          .i_b  (w_cry[i][k]),
          .i_c  (w_pp),
          .o_sum(w_sum[i+1][k]),
          .o_cry(w_cry[i+1][k+1])
        );
      end else begin : g_msb
        assign w_sum[i+1][k] = w_sum[i][k] ^ w_cry[i][k] ^ w_pp;
      end
    end
  end

  // Final ripple-carry row; the product never overflows, so the MSB carry is not formed.
  assign w_rc[0] = 1'b0;
  for (genvar k = 0; k < RES_W; k++) begin : g_rca
    if (k < RES_W-1) begin : g_fa
      bam_full_adder u_fa (
        .i_a  (w_sum[OP_W][k]),
        .i_b  (w_cry[OP_W][k]),
        .i_c  (w_rc[k]),
        .o_sum(w_p[k]),
        .o_cry(w_rc[k+1])
      );
    end else begin : g_msb
      assign w_p[k] = w_sum[OP_W][k] ^ w_cry[OP_W][k] ^ w_rc[k];
    end
    assign w_p_locked[k] = key_gate(w_p[k], keyinput[k], KEY_CORRECT[k]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_result <= '0;
    else         r_result <= w_p_locked;
  end

  assign result_o = r_result;
endmodule

// File: tb/tb_broken_array_multiplier8_xor_enc32.sv
// Scoreboard bench: driver queues expected results, monitor checks each captured product.
module tb_broken_array_multiplier8_xor_enc32;
  localparam logic [31:0] KC = 32'hB544B006;
  localparam int TB_HBL = 0;
  localparam int TB_VBL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic [31:0] key = KC;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  broken_array_multiplier8_xor_enc32 dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .operand1_i(op_a),
    .operand2_i(op_b),
    .keyinput  (key),
    .result_o  (result)
  );

  always #5 clk = ~clk;

  // Reference: sum of kept partial products by weight, then apply key mismatches.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [31:0] k);
    logic [31:0] d;
    logic [7:0]  ae, be;
    int unsigned p;
    d  = k ^ KC;
    ae = a ^ d[23:16];
    be = b ^ d[31:24];
    p  = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i >= TB_HBL && i + j >= TB_VBL && ae[j] && be[i]) p += (1 << (i + j));
    return p[15:0] ^ d[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [31:0] k,
                       input logic [15:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    op_a = a; op_b = b; key = k;
    e.exp = exp; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, result, e.exp);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0]  a, b;
    logic [31:0] k;
    op_a = 8'h29; op_b = 8'h7A;
    #1 rst_n = 1'b0;
    #2 check("reset_async", result, 16'h0000);
    @(posedge clk); #1;
    check("reset_held", result, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      e.exp = 16'h1380; e.name = "reset_release";
      exp_q.push_back(e);
    end

    apply(8'h11, 8'h11, KC, 16'h0120, "ck_11x11");
    apply(8'h89, 8'hFF, KC, 16'h8860, "ck_89xFF");
    apply(8'h80, 8'h80, KC, 16'h4000, "ck_80x80");
    apply(8'h40, 8'h20, KC, 16'h0800, "ck_40x20");
    apply(8'hAB, 8'h00, KC, 16'h0000, "ck_ABx00");
    apply(8'h00, 8'h01, KC, 16'h0000, "ck_00x01");
    apply(8'h11, 8'h11, 32'hB544B007, 16'h0121, "res_gate_d0");
    apply(8'h00, 8'h00, 32'h3544B006, 16'h0000, "b7_gate_zero");
    apply(8'h11, 8'h11, 32'hB545B006, 16'h0110, "a0_gate_d16");
    apply(8'h01, 8'h07, KC, 16'h0000, "broken_01x07");
    apply(8'h0F, 8'h0F, KC, 16'h00B0, "broken_0Fx0F");
    apply(8'h01, 8'h01, KC, 16'h0000, "broken_01x01");
    apply(8'hFF, 8'hFF, KC, model(8'hFF, 8'hFF, KC), "max_FFxFF");

    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      apply(a, b, KC, model(a, b, KC), "rand_correct_key");
    end
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      k = $urandom;
      if (k == KC) k = k ^ 32'h0000_0001;
      apply(a, b, k, model(a, b, k), "rand_wrong_key");
    end

    // Mid-operation reset: output clears at once, next capture uses live inputs.
    apply(8'hC3, 8'h5A, KC, model(8'hC3, 8'h5A, KC), "pre_midreset");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check("midreset_async", result, 16'h0000);
    @(negedge clk);
    op_a = 8'h29; op_b = 8'h7A; key = KC;
    rst_n = 1'b1;
    begin
      exp_t e;
      e.exp = 16'h1380; e.name = "midreset_release";
      exp_q.push_back(e);
    end

    for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
    @(posedge clk); #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
